// File: rtl/idex_ctrl_pipe_if.sv
// ID/EX control bundle: ID-side fields (_d) and hazard controls in, registered EX copies (_e) and status out.
interface idex_ctrl_pipe_if #(
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
);
  logic                   valid_d,     valid_e;
  logic [3:0]             aluctrl_d,   aluctrl_e;
  logic [2:0]             aluctrl1_d,  aluctrl1_e;
  logic [1:0]             alusrca_d,   alusrca_e;
  logic                   alusrcb_d,   alusrcb_e;
  logic                   memwrite_d,  memwrite_e;
  logic                   lunsigned_d, lunsigned_e;
  logic                   j_d,         j_e;
  logic                   btype_d,     btype_e;
  logic                   memtoreg_d,  memtoreg_e;
  logic                   regwrite_d,  regwrite_e;
  logic [1:0]             lwhb_d,      lwhb_e;
  logic [1:0]             swhb_d,      swhb_e;
  logic [RFIDX_WIDTH-1:0] rd_d,        rd_e;
  logic [RFIDX_WIDTH-1:0] rs1_d,       rs1_e;
  logic [RFIDX_WIDTH-1:0] rs2_d,       rs2_e;
  logic                   use_rs1_d,   use_rs1_e;
  logic                   use_rs2_d,   use_rs2_e;
  logic                   flush_e;
  logic                   stall_ext;
  logic                   stall_d;
  logic [CNT_WIDTH-1:0]   bubble_cnt;

  modport master (
    output valid_d, aluctrl_d, aluctrl1_d, alusrca_d, alusrcb_d, memwrite_d,
           lunsigned_d, j_d, btype_d, memtoreg_d, regwrite_d, lwhb_d, swhb_d,
           rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, flush_e, stall_ext,
    input  valid_e, aluctrl_e, aluctrl1_e, alusrca_e, alusrcb_e, memwrite_e,
           lunsigned_e, j_e, btype_e, memtoreg_e, regwrite_e, lwhb_e, swhb_e,
           rd_e, rs1_e, rs2_e, use_rs1_e, use_rs2_e, stall_d, bubble_cnt
  );

  modport slave (
    input  valid_d, aluctrl_d, aluctrl1_d, alusrca_d, alusrcb_d, memwrite_d,
           lunsigned_d, j_d, btype_d, memtoreg_d, regwrite_d, lwhb_d, swhb_d,
           rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, flush_e, stall_ext,
    output valid_e, aluctrl_e, aluctrl1_e, alusrca_e, alusrcb_e, memwrite_e,
           lunsigned_e, j_e, btype_e, memtoreg_e, regwrite_e, lwhb_e, swhb_e,
           rd_e, rs1_e, rs2_e, use_rs1_e, use_rs2_e, stall_d, bubble_cnt
  );
endinterface

// File: rtl/idex_ctrl_pipe.sv
// ID/EX control pipeline register with load-use hazard detection, flush bubbles
// and a saturating bubble counter.
module idex_ctrl_pipe #(
  parameter int RFIDX_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  idex_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic [3:0]             aluctrl;
    logic [2:0]             aluctrl1;
    logic [1:0]             alusrca;
    logic                   alusrcb;
    logic                   memwrite;
    logic                   lunsigned;
    logic                   j;
    logic                   btype;
    logic                   memtoreg;
    logic                   regwrite;
    logic [1:0]             lwhb;
    logic [1:0]             swhb;
    logic                   use_rs1;
    logic                   use_rs2;
    logic [RFIDX_WIDTH-1:0] rd;
    logic [RFIDX_WIDTH-1:0] rs1;
    logic [RFIDX_WIDTH-1:0] rs2;
  } ctrl_t;

  ctrl_t                r_ex_p1;
  logic                 r_vld_p1;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;
  logic                 r_post_rst;
  ctrl_t                w_cap;
  logic                 w_lu_hazard;
  logic                 w_bubble;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    w_cap           = '0;
    w_cap.rd        = bus.rd_d;
    w_cap.rs1       = bus.rs1_d;
    w_cap.rs2       = bus.rs2_d;
    // An empty ID slot carries its indices but never any control that could retire.
    if (bus.valid_d) begin
      w_cap.aluctrl   = bus.aluctrl_d;
      w_cap.aluctrl1  = bus.aluctrl1_d;
      w_cap.alusrca   = bus.alusrca_d;
      w_cap.alusrcb   = bus.alusrcb_d;
      w_cap.memwrite  = bus.memwrite_d;
      w_cap.lunsigned = bus.lunsigned_d;
      w_cap.j         = bus.j_d;
      w_cap.btype     = bus.btype_d;
      w_cap.memtoreg  = bus.memtoreg_d;
      w_cap.regwrite  = bus.regwrite_d;
      w_cap.lwhb      = bus.lwhb_d;
      w_cap.swhb      = bus.swhb_d;
      w_cap.use_rs1   = bus.use_rs1_d;
      w_cap.use_rs2   = bus.use_rs2_d;
    end
  end

  assign w_lu_hazard = r_vld_p1 & r_ex_p1.memtoreg & (r_ex_p1.rd != '0) & bus.valid_d &
                       ((bus.use_rs1_d & (bus.rs1_d == r_ex_p1.rd)) |
                        (bus.use_rs2_d & (bus.rs2_d == r_ex_p1.rd)));
  assign w_bubble    = bus.flush_e | w_lu_hazard;
  assign bus.stall_d = ~reset & ~r_post_rst &
                       (bus.stall_ext | (w_lu_hazard & ~bus.flush_e));

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_p1      <= '0;
      r_vld_p1     <= 1'b0;
      r_bubble_cnt <= '0;
      r_post_rst   <= 1'b1;
    end else begin
      r_post_rst <= 1'b0;
      if (!bus.stall_ext) begin
        if (w_bubble) begin
          r_ex_p1      <= '0;
          r_vld_p1     <= 1'b0;
          r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end else begin
          r_ex_p1  <= w_cap;
          r_vld_p1 <= bus.valid_d;
        end
      end
    end
  end

  assign bus.valid_e     = r_vld_p1;
  assign bus.aluctrl_e   = r_ex_p1.aluctrl;
  assign bus.aluctrl1_e  = r_ex_p1.aluctrl1;
  assign bus.alusrca_e   = r_ex_p1.alusrca;
  assign bus.alusrcb_e   = r_ex_p1.alusrcb;
  assign bus.memwrite_e  = r_ex_p1.memwrite;
  assign bus.lunsigned_e = r_ex_p1.lunsigned;
  assign bus.j_e         = r_ex_p1.j;
  assign bus.btype_e     = r_ex_p1.btype;
  assign bus.memtoreg_e  = r_ex_p1.memtoreg;
  assign bus.regwrite_e  = r_ex_p1.regwrite;
  assign bus.lwhb_e      = r_ex_p1.lwhb;
  assign bus.swhb_e      = r_ex_p1.swhb;
  assign bus.use_rs1_e   = r_ex_p1.use_rs1;
  assign bus.use_rs2_e   = r_ex_p1.use_rs2;
  assign bus.rd_e        = r_ex_p1.rd;
  assign bus.rs1_e       = r_ex_p1.rs1;
  assign bus.rs2_e       = r_ex_p1.rs2;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// Directed bench for idex_ctrl_pipe: reset, load-use stall, x0 load, flush priority,
// external stall freeze and counter saturation on a 4-bit instance.
module tb_idex_ctrl_pipe;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  idex_ctrl_pipe_if #(.RFIDX_WIDTH(5), .CNT_WIDTH(16)) if1 ();
  idex_ctrl_pipe_if #(.RFIDX_WIDTH(5), .CNT_WIDTH(4))  if2 ();

  idex_ctrl_pipe #(.RFIDX_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(if1)
  );
  idex_ctrl_pipe #(.RFIDX_WIDTH(5), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d1();
    if1.valid_d = 0; if1.aluctrl_d = 0; if1.aluctrl1_d = 0; if1.alusrca_d = 0;
    if1.alusrcb_d = 0; if1.memwrite_d = 0; if1.lunsigned_d = 0; if1.j_d = 0;
    if1.btype_d = 0; if1.memtoreg_d = 0; if1.regwrite_d = 0; if1.lwhb_d = 0;
    if1.swhb_d = 0; if1.rd_d = 0; if1.rs1_d = 0; if1.rs2_d = 0;
    if1.use_rs1_d = 0; if1.use_rs2_d = 0; if1.flush_e = 0; if1.stall_ext = 0;
  endtask

  task automatic clr_d2();
    if2.valid_d = 0; if2.aluctrl_d = 0; if2.aluctrl1_d = 0; if2.alusrca_d = 0;
    if2.alusrcb_d = 0; if2.memwrite_d = 0; if2.lunsigned_d = 0; if2.j_d = 0;
    if2.btype_d = 0; if2.memtoreg_d = 0; if2.regwrite_d = 0; if2.lwhb_d = 0;
    if2.swhb_d = 0; if2.rd_d = 0; if2.rs1_d = 0; if2.rs2_d = 0;
    if2.use_rs1_d = 0; if2.use_rs2_d = 0; if2.flush_e = 0; if2.stall_ext = 0;
  endtask

  // Load writing rd.
  task automatic set_load(input logic [4:0] rd);
    clr_d1();
    if1.valid_d = 1; if1.memtoreg_d = 1; if1.regwrite_d = 1; if1.lwhb_d = 2'b11; if1.rd_d = rd;
  endtask

  // ALU op reading rs1 and rs2.
  task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    clr_d1();
    if1.valid_d = 1; if1.regwrite_d = 1; if1.aluctrl_d = 4'd2; if1.rd_d = rd;
    if1.rs1_d = rs1; if1.use_rs1_d = 1; if1.rs2_d = rs2; if1.use_rs2_d = 1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr_d1();
    clr_d2();

    // T1: reset with a live instruction and external stall presented
    reset = 1;
    if1.valid_d = 1; if1.regwrite_d = 1; if1.aluctrl_d = 4'd5; if1.stall_ext = 1;
    tick();
    tick();
    check("t1_valid_e",    if1.valid_e,    0);
    check("t1_regwrite_e", if1.regwrite_e, 0);
    check("t1_aluctrl_e",  if1.aluctrl_e,  0);
    check("t1_bubble_cnt", if1.bubble_cnt, 0);
    check("t1_stall_d",    if1.stall_d,    0);
    reset = 0;
    clr_d1();

    // T2: lw x5 then add x6,x5,x1
    set_load(5);
    tick();
    check("t2_lw_valid_e",    if1.valid_e,    1);
    check("t2_lw_memtoreg_e", if1.memtoreg_e, 1);
    check("t2_lw_rd_e",       if1.rd_e,       5);
    set_alu(6, 5, 1);
    #1;
    check("t2_stall_d_hi", if1.stall_d, 1);
    tick();
    check("t2_bub_valid_e",    if1.valid_e,    0);
    check("t2_bub_regwrite_e", if1.regwrite_e, 0);
    check("t2_bub_rd_e",       if1.rd_e,       0);
    check("t2_bub_cnt",        if1.bubble_cnt, 1);
    check("t2_stall_d_lo",     if1.stall_d,    0);
    tick();
    check("t2_add_valid_e",   if1.valid_e,   1);
    check("t2_add_rd_e",      if1.rd_e,      6);
    check("t2_add_rs1_e",     if1.rs1_e,     5);
    check("t2_add_aluctrl_e", if1.aluctrl_e, 2);

    // T3: lw x0 followed by a reader of x0
    set_load(0);
    tick();
    set_alu(3, 0, 0);
    #1;
    check("t3_stall_d", if1.stall_d, 0);
    tick();
    check("t3_valid_e", if1.valid_e,    1);
    check("t3_rd_e",    if1.rd_e,       3);
    check("t3_cnt",     if1.bubble_cnt, 1);

    // T4: hazard coincident with flush
    set_load(7);
    tick();
    set_alu(8, 2, 7);
    if1.flush_e = 1;
    #1;
    check("t4_stall_d", if1.stall_d, 0);
    tick();
    check("t4_valid_e", if1.valid_e,    0);
    check("t4_cnt",     if1.bubble_cnt, 2);
    if1.flush_e = 0;
    tick();
    check("t4_add_rd_e", if1.rd_e,       8);
    check("t4_cnt_hold", if1.bubble_cnt, 2);

    // T5: external stall with pending flush and changing ID fields
    for (int i = 0; i < 3; i++) begin
      set_alu(5'(9 + i), 1, 2);
      if1.stall_ext = 1;
      if1.flush_e   = 1;
      #1;
      check("t5_stall_d", if1.stall_d, 1);
      tick();
      check("t5_rd_e_frozen",    if1.rd_e,       8);
      check("t5_valid_e_frozen", if1.valid_e,    1);
      check("t5_cnt_frozen",     if1.bubble_cnt, 2);
    end
    if1.stall_ext = 0;
    tick();
    check("t5_flush_valid_e", if1.valid_e,    0);
    check("t5_flush_rd_e",    if1.rd_e,       0);
    check("t5_flush_cnt",     if1.bubble_cnt, 3);
    if1.flush_e = 0;
    tick();
    check("t5_resume_rd_e",    if1.rd_e,    11);
    check("t5_resume_valid_e", if1.valid_e, 1);

    // Empty ID slot: controls zeroed, not a bubble
    set_load(12);
    if1.valid_d = 0;
    tick();
    check("nv_valid_e",    if1.valid_e,    0);
    check("nv_regwrite_e", if1.regwrite_e, 0);
    check("nv_memtoreg_e", if1.memtoreg_e, 0);
    check("nv_cnt",        if1.bubble_cnt, 3);

    // T6: saturation of a 4-bit counter
    if2.flush_e = 1;
    for (int i = 0; i < 14; i++) tick();
    check("t6_cnt_14", if2.bubble_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    check("t6_cnt_sat", if2.bubble_cnt, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    check("t6_cnt_hold", if2.bubble_cnt, 4'hF);
    check("t6_valid_e",  if2.valid_e,    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
